// File: rtl/rca_nibble_seq_ctrl_if.sv
// Operand, adder and result bundle of the nibble-serial adder sequencer.
// The master is the sequencer; the slave side is the operand source, external adder and result sink.
interface rca_nibble_seq_ctrl_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // Once valid is raised, the producer holds valid and data steady until that edge.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;

    logic [3:0]   rca_a;
    logic [3:0]   rca_b;
    logic         rca_cin;
    logic [3:0]   rca_s;
    logic         rca_cout;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    logic         busy;

    modport master (
        input  in_valid, in_a, in_b, in_cin, rca_s, rca_cout, out_ready,
        output in_ready, rca_a, rca_b, rca_cin, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        output in_valid, in_a, in_b, in_cin, rca_s, rca_cout, out_ready,
        input  in_ready, rca_a, rca_b, rca_cin, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/rca_nibble_seq_ctrl.sv
// Adds two W-bit operands one nibble per clock through an external 4-bit ripple-carry adder.
// The adder runs LSB nibble first, and its sum and carry are registered every ADD cycle.
module rca_nibble_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rca_nibble_seq_ctrl_if.master bus,
    output logic [1:0]            dbg_state
);
    localparam int W  = 4 * NIB;
    localparam int IW = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [W-1:0]  out_sum_q;
    logic          out_cout_q;
    logic          last;

    assign last = (idx == IW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        carry      <= bus.in_cin;
                        idx        <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    sum_q[{idx, 2'b00} +: 4] <= bus.rca_s;
                    carry                    <= bus.rca_cout;
                    if (last) begin
                        // The top nibble arrives this cycle, so merge it straight into the result.
                        out_sum_q   <= {bus.rca_s, sum_q[W-5:0]};
                        out_cout_q  <= bus.rca_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The adder inputs are quiet outside ADD, so it sees no stale operands.
    assign bus.rca_a   = (state == ADD) ? a_q[{idx, 2'b00} +: 4] : 4'h0;
    assign bus.rca_b   = (state == ADD) ? b_q[{idx, 2'b00} +: 4] : 4'h0;
    assign bus.rca_cin = (state == ADD) ? carry : 1'b0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_rca_nibble_seq_ctrl.sv
// Bench for rca_nibble_seq_ctrl: directed vectors plus a random source/sink run with a scoreboard.
// The external 4-bit adder is modelled here as a plain combinational add.
module tb_rca_nibble_seq_ctrl;
    localparam int NIB  = 4;
    localparam int W    = 4 * NIB;
    localparam int NOPS = 1000;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    logic [W:0] exp_q[$];

    rca_nibble_seq_ctrl_if #(.NIB(NIB)) bus ();

    rca_nibble_seq_ctrl #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    assign {bus.rca_cout, bus.rca_s} = {1'b0, bus.rca_a} + {1'b0, bus.rca_b} + {4'h0, bus.rca_cin};

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand pair in IDLE and return just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        bus.in_cin   = 1'b0;
    endtask

    // Count edges after the accept until out_valid rises, with a bound on the wait.
    task automatic wait_done(input bit chk_cin);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("busy_add", 32'(bus.busy), 32'd1);
            if (chk_cin) check("rca_cin_one", 32'(bus.rca_cin), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NIB));
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_taken", 32'(bus.out_valid), 32'd0);
        check("in_ready_after", 32'(bus.in_ready), 32'd1);
        check("busy_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   e;
        int           sent;
        int           rcvd;
        int           cyc;
        int           extra;
        bit           acc;

        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_cout", 32'(bus.out_cout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rca_a", 32'(bus.rca_a), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x1234 + 0x4321: first nibble pair presented right after the accept
        start_op(16'h1234, 16'h4321, 1'b0);
        check("add_rca_a0", 32'(bus.rca_a), 32'h4);
        check("add_rca_b0", 32'(bus.rca_b), 32'h1);
        check("add_state", 32'(dbg_state), 32'd1);
        wait_done(1'b0);
        check("sum_5555", 32'(bus.out_sum), 32'h5555);
        check("cout_5555", 32'(bus.out_cout), 32'd0);

        // Back-pressure: hold the result for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum", 32'(bus.out_sum), 32'h5555);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
            check("bp_rca_a", 32'(bus.rca_a), 32'd0);
        end
        take_result();
        check("hold_sum_idle", 32'(bus.out_sum), 32'h5555);

        // Carry ripples through every nibble
        start_op(16'hFFFF, 16'h0000, 1'b1);
        wait_done(1'b1);
        check("sum_ripple", 32'(bus.out_sum), 32'h0000);
        check("cout_ripple", 32'(bus.out_cout), 32'd1);
        take_result();

        // All-ones operands with carry-in
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(1'b1);
        check("sum_ones", 32'(bus.out_sum), 32'hFFFF);
        check("cout_ones", 32'(bus.out_cout), 32'd1);
        take_result();

        // Reset while idx is 2: abandon the op
        start_op(16'h8888, 16'h8888, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_state_add", 32'(dbg_state), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) extra++;
        end
        check("mid_rst_no_valid", 32'(extra), 32'd0);

        // Random source/sink gaps against the scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        acc  = 1'b0;
        a    = '0;
        b    = '0;
        cin  = 1'b0;
        while (rcvd < NOPS && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (acc) bus.in_valid = 1'b0;
            acc = 1'b0;
            if (!bus.in_valid) begin
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
                if (sent < NOPS && $urandom_range(0, 3) != 0) begin
                    a            = W'($urandom);
                    b            = W'($urandom);
                    cin          = 1'($urandom_range(0, 1));
                    bus.in_a     = a;
                    bus.in_b     = b;
                    bus.in_cin   = cin;
                    bus.in_valid = 1'b1;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                sent++;
                acc = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_sum", 32'({bus.out_cout, bus.out_sum}), 32'(e));
                end
                rcvd++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rand_sent", 32'(sent), 32'(NOPS));
        check("rand_rcvd", 32'(rcvd), 32'(NOPS));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) extra++;
        end
        check("rand_no_dup", 32'(extra), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
